fifo_write_arbiter: RTL and testbench

Round-robin write arbiter that shares one `synchronous_fifo` write port between NREQ requesters. Each cycle it grants at most one requester, forwards that requester's data word to the FIFO write port, and never writes while the FIFO reports full. It sits directly in front of the FIFO and drives its `wr_en`/`din`, taking `full` back as back-pressure. The FIFO read side is not touched.

---
 rtl/fifo_write_arbiter.sv | 177 +++++++++++++++++
 tb/tb_fifo_write_arbiter.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/fifo_write_arbiter.sv
// fifo_write_arbiter: round-robin arbiter sharing one FIFO write port
// between NREQ requesters. Grant, write enable and write data are
// combinational; the priority pointer and last grant index are registered.
// Optional macro FIFO_ARB_BURST_EN lets a granted requester keep the port
// for up to BURST_LEN consecutive beats.
module fifo_write_arbiter #(
    parameter int NREQ      = 4,
    parameter int DSIZE     = 8,
    parameter int BURST_LEN = 4
) (
    input  logic                      clk,
    input  logic                      rstn,
    input  logic [NREQ-1:0]           req,
    input  logic [NREQ*DSIZE-1:0]     req_data,
    output logic [NREQ-1:0]           gnt,
    input  logic                      fifo_full,
    output logic                      fifo_wr_en,
    output logic [DSIZE-1:0]          fifo_din,
    output logic [$clog2(NREQ)-1:0]   last_id
);

    localparam int IW = $clog2(NREQ);

    // Reject parameter values the arbiter is not built for.
    generate
        if (NREQ < 2 || NREQ > 16) begin : g_bad_nreq
            $error("fifo_write_arbiter: NREQ must be 2..16");
        end
        if (BURST_LEN < 1 || BURST_LEN > 255) begin : g_bad_burst
            $error("fifo_write_arbiter: BURST_LEN must be 1..255");
        end
    endgenerate

    // (base + off) modulo NREQ, valid for off in 0..NREQ
    function automatic logic [IW-1:0] wrap_add(input logic [IW-1:0] base, input int off);
        int sum;
        sum = int'(base) + off;
        if (sum >= NREQ) begin
            sum = sum - NREQ;
        end else begin
            sum = sum;
        end
        return sum[IW-1:0];
    endfunction

    logic [IW-1:0]    r_ptr;
    logic [IW-1:0]    r_last_id;
    logic             w_found;
    logic [IW-1:0]    w_rr_idx;
    logic [IW-1:0]    w_gnt_idx;
    logic             w_grant_ok;
    logic [NREQ-1:0]  w_gnt;
    logic [DSIZE-1:0] w_din;

`ifdef FIFO_ARB_BURST_EN
    typedef enum logic {ST_IDLE = 1'b0, ST_BURST = 1'b1} state_t;

    localparam logic [7:0] BURST_LEN_C = 8'(BURST_LEN);

    state_t        r_state;
    logic [IW-1:0] r_owner;
    logic [7:0]    r_beat_cnt;
`endif

    // Find the first asserted request scanning upward from the pointer.
    always_comb begin
        w_found  = 1'b0;
        w_rr_idx = '0;
        for (int k = 0; k < NREQ; k++) begin
            if (!w_found && req[wrap_add(r_ptr, k)]) begin
                w_found  = 1'b1;
                w_rr_idx = wrap_add(r_ptr, k);
            end else begin
                w_rr_idx = w_rr_idx;
            end
        end
    end

    // Decide whether a grant happens this cycle and to whom.
    always_comb begin
`ifdef FIFO_ARB_BURST_EN
        if (r_state == ST_BURST) begin
            w_gnt_idx  = r_owner;
            w_grant_ok = req[r_owner] & ~fifo_full & rstn;
        end else begin
            w_gnt_idx  = w_rr_idx;
            w_grant_ok = w_found & ~fifo_full & rstn;
        end
`else
        w_gnt_idx  = w_rr_idx;
        w_grant_ok = w_found & ~fifo_full & rstn;
`endif
    end

    // One-hot grant and the matching data word (zero when idle).
    always_comb begin
        w_gnt = '0;
        w_din = '0;
        if (w_grant_ok) begin
            w_gnt[w_gnt_idx] = 1'b1;
        end else begin
            w_gnt = '0;
        end
        for (int i = 0; i < NREQ; i++) begin
            if (w_gnt[i]) begin
                w_din = req_data[i*DSIZE +: DSIZE];
            end else begin
                w_din = w_din;
            end
        end
    end

    assign gnt        = w_gnt;
    assign fifo_wr_en = |w_gnt;
    assign fifo_din   = w_din;
    assign last_id    = r_last_id;

`ifdef FIFO_ARB_BURST_EN
    // Burst FSM: hold the port for the owner until it drops req or hits BURST_LEN.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_state    <= ST_IDLE;
            r_owner    <= '0;
            r_beat_cnt <= 8'd0;
            r_ptr      <= '0;
            r_last_id  <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_grant_ok) begin
                        r_last_id <= w_gnt_idx;
                        if (BURST_LEN_C <= 8'd1) begin
                            r_ptr <= wrap_add(w_gnt_idx, 1);
                        end else begin
                            r_state    <= ST_BURST;
                            r_owner    <= w_gnt_idx;
                            r_beat_cnt <= 8'd1;
                        end
                    end
                end
                ST_BURST: begin
                    if (!req[r_owner]) begin
                        r_state    <= ST_IDLE;
                        r_ptr      <= wrap_add(r_owner, 1);
                        r_beat_cnt <= 8'd0;
                    end else if (w_grant_ok) begin
                        r_last_id <= r_owner;
                        if ((r_beat_cnt + 8'd1) == BURST_LEN_C) begin
                            r_state    <= ST_IDLE;
                            r_ptr      <= wrap_add(r_owner, 1);
                            r_beat_cnt <= 8'd0;
                        end else begin
                            r_beat_cnt <= r_beat_cnt + 8'd1;
                        end
                    end
                end
                default: begin
                    r_state    <= ST_IDLE;
                    r_beat_cnt <= 8'd0;
                end
            endcase
        end
    end
`else
    // Advance the pointer past the granted requester; hold when nothing is written.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_ptr     <= '0;
            r_last_id <= '0;
        end else if (w_grant_ok) begin
            r_ptr     <= wrap_add(w_gnt_idx, 1);
            r_last_id <= w_gnt_idx;
        end
    end
`endif

endmodule

// File: tb/tb_fifo_write_arbiter.sv
// Bench for fifo_write_arbiter (default build, NREQ=4, DSIZE=8): vector table
// for arbitration order, a FIFO model plus scoreboard for back-pressure, and
// hand sequences for pointer hold and asynchronous reset.
module tb_fifo_write_arbiter;

    logic        clk = 1'b0;
    logic        rstn;
    logic [3:0]  req_drv;
    logic [31:0] req_data;
    logic [3:0]  gnt;
    logic        full_drv;
    logic        wr_en;
    logic [7:0]  din;
    logic [1:0]  last_id;
    logic [7:0]  dat [4];

    assign req_data = {dat[3], dat[2], dat[1], dat[0]};

    always #5 clk = ~clk;

    fifo_write_arbiter #(.NREQ(4), .DSIZE(8), .BURST_LEN(4)) dut (
        .clk        (clk),
        .rstn       (rstn),
        .req        (req_drv),
        .req_data   (req_data),
        .gnt        (gnt),
        .fifo_full  (full_drv),
        .fifo_wr_en (wr_en),
        .fifo_din   (din),
        .last_id    (last_id)
    );

    typedef struct {
        logic [3:0] req;
        logic       full;
        logic [3:0] gnt;
        logic [7:0] din;
        logic [1:0] last;
    } vec_t;

    vec_t       tbl [$];
    logic [7:0] fifo_q [$];
    logic [7:0] exp_q [$];
    int         n_vec = 0;
    int         n_bad = 0;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, got, exp);
        end
    endtask

    task automatic check_out(input string tag, input logic [3:0] eg, input logic [7:0] ed, input logic [1:0] el);
        check({tag, ".gnt"},     32'(gnt),     32'(eg));
        check({tag, ".wr_en"},   32'(wr_en),   32'(|eg));
        check({tag, ".din"},     32'(din),     32'(ed));
        check({tag, ".last_id"}, 32'(last_id), 32'(el));
    endtask

    task automatic pop_compare(input string tag);
        logic [7:0] got_w;
        logic [7:0] exp_w;
        if (fifo_q.size() == 0 || exp_q.size() == 0) begin
            n_vec++;
            n_bad++;
            $display("FAIL %s: fifo model has %0d words, scoreboard has %0d", tag, fifo_q.size(), exp_q.size());
        end else begin
            got_w = fifo_q.pop_front();
            exp_w = exp_q.pop_front();
            check(tag, 32'(got_w), 32'(exp_w));
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic add(input logic [3:0] r, input logic f, input logic [3:0] g, input logic [7:0] d, input logic [1:0] l);
        vec_t v;
        v.req = r; v.full = f; v.gnt = g; v.din = d; v.last = l;
        tbl.push_back(v);
    endtask

    initial begin
        int         nw;
        int         stall;
        logic       wrote;
        logic [7:0] d;

        // idle after reset
        for (int i = 0; i < 5; i++) add(4'b0000, 1'b0, 4'b0000, 8'h00, 2'd0);
        // full contention
        add(4'b1111, 1'b0, 4'b0001, 8'hA0, 2'd0);
        add(4'b1111, 1'b0, 4'b0010, 8'hA1, 2'd0);
        add(4'b1111, 1'b0, 4'b0100, 8'hA2, 2'd1);
        add(4'b1111, 1'b0, 4'b1000, 8'hA3, 2'd2);
        add(4'b1111, 1'b0, 4'b0001, 8'hA0, 2'd3);
        add(4'b1111, 1'b0, 4'b0010, 8'hA1, 2'd0);
        add(4'b1111, 1'b0, 4'b0100, 8'hA2, 2'd1);
        add(4'b1111, 1'b0, 4'b1000, 8'hA3, 2'd2);
        // sparse requests from ptr=0
        add(4'b1010, 1'b0, 4'b0010, 8'hA1, 2'd3);
        add(4'b1010, 1'b0, 4'b1000, 8'hA3, 2'd1);
        add(4'b1010, 1'b0, 4'b0010, 8'hA1, 2'd3);
        // full blocks and holds ptr, wrap-around scans
        add(4'b1111, 1'b1, 4'b0000, 8'h00, 2'd1);
        add(4'b1111, 1'b0, 4'b0100, 8'hA2, 2'd1);
        add(4'b0001, 1'b0, 4'b0001, 8'hA0, 2'd2);
        add(4'b0001, 1'b1, 4'b0000, 8'h00, 2'd0);
        add(4'b1001, 1'b0, 4'b1000, 8'hA3, 2'd0);
        add(4'b0100, 1'b0, 4'b0100, 8'hA2, 2'd3);

        dat[0] = 8'hA0; dat[1] = 8'hA1; dat[2] = 8'hA2; dat[3] = 8'hA3;
        rstn     = 1'b0;
        req_drv  = 4'b1111;
        full_drv = 1'b0;
        @(negedge clk);
        check_out("reset", 4'b0000, 8'h00, 2'd0);
        step();
        rstn    = 1'b1;
        req_drv = 4'b0000;

        foreach (tbl[i]) begin
            req_drv  = tbl[i].req;
            full_drv = tbl[i].full;
            @(negedge clk);
            check_out($sformatf("vec%0d", i), tbl[i].gnt, tbl[i].din, tbl[i].last);
            step();
        end

        // Fill a 16-deep FIFO model from requester 2, stall, pop one, resume.
        fifo_q.delete();
        exp_q.delete();
        req_drv = 4'b0100;
        nw      = 0;
        stall   = 0;
        exp_q.push_back(8'h10);
        for (int c = 0; c < 80 && nw < 17; c++) begin
            full_drv = (fifo_q.size() >= 16);
            dat[2]   = 8'h10 + 8'(nw);
            @(negedge clk);
            if (full_drv) check_out($sformatf("fill_stall%0d", c), 4'b0000, 8'h00, 2'd2);
            else          check_out($sformatf("fill%0d", c), 4'b0100, 8'h10 + 8'(nw), 2'd2);
            wrote = wr_en;
            d     = din;
            step();
            if (wrote) begin
                fifo_q.push_back(d);
                nw++;
                if (nw < 17) exp_q.push_back(8'h10 + 8'(nw));
            end
            if (full_drv) begin
                stall++;
                if (stall == 3) begin
                    pop_compare("sb_pop_while_full");
                    stall = 0;
                end
            end
        end
        check("fill_word_count", 32'(nw), 32'd17);
        for (int i = 0; i < 16; i++) pop_compare($sformatf("sb_drain%0d", i));
        check("sb_leftover", 32'(exp_q.size()), 32'd0);
        check("fifo_leftover", 32'(fifo_q.size()), 32'd0);

        // Pointer (now 3) must survive a full stall: req 0110 resumes at requester 1.
        dat[2]   = 8'hA2;
        req_drv  = 4'b0110;
        full_drv = 1'b1;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            check_out($sformatf("hold_stall%0d", i), 4'b0000, 8'h00, 2'd2);
            step();
        end
        full_drv = 1'b0;
        @(negedge clk);
        check_out("hold_resume", 4'b0010, 8'hA1, 2'd2);
        step();

        // Reset mid-stream with ptr=3: outputs drop at once, restart at requester 0.
        req_drv = 4'b1111;
        @(negedge clk);
        check_out("pre_rst0", 4'b0100, 8'hA2, 2'd1);
        step();
        #1;
        rstn = 1'b0;
        #1;
        check_out("in_rst", 4'b0000, 8'h00, 2'd0);
        step();
        rstn = 1'b1;
        @(negedge clk);
        check_out("post_rst", 4'b0001, 8'hA0, 2'd0);
        step();
        @(negedge clk);
        check_out("post_rst1", 4'b0010, 8'hA1, 2'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
